serpent_round_engine: RTL and testbench

//   Iterative Serpent-128 encryption round core, one round per clock. Accepts a bitsliced

---
 rtl/serpent_pkg.sv | 45 ++++
 rtl/serpent_linear_transform.sv | 33 +++
 rtl/serpent_round_engine.sv | 106 ++++++++++
 tb/tb_serpent_round_engine.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// Shared definitions for the Serpent-128 datapath.
//   SBOX                 : the eight 4-bit Serpent S-box tables.
//   sbox_slice()         : applies one S-box to a bitsliced 128-bit state.
//   rotl32()             : 32-bit rotate-left helper.
//   state_t              : 128-bit bitsliced state, X_k = state[32k+31:32k].
//   SERPENT_ROUNDS / SERPENT_NUM_SUBKEYS : algorithm constants.
package serpent_pkg;

    localparam int SERPENT_ROUNDS      = 32;
    localparam int SERPENT_NUM_SUBKEYS = 33;

    typedef logic [127:0] state_t;

    localparam logic [3:0] SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4},
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2},
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1},
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0},
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6}
    };

    // Bit j of each of the four words forms one nibble, X0 being the LSB.
    function automatic state_t sbox_slice(input logic [2:0] idx, input state_t s);
        state_t     r;
        logic [3:0] nib;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            nib       = {s[96+j], s[64+j], s[32+j], s[j]};
            nib       = SBOX[idx][nib];
            r[j]      = nib[0];
            r[32+j]   = nib[1];
            r[64+j]   = nib[2];
            r[96+j]   = nib[3];
        end
        return r;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
        return (v << n) | (v >> (32 - n));
    endfunction

endpackage

// File: rtl/serpent_linear_transform.sv
// Serpent linear transformation, purely combinational.
//   i_state : 128-bit bitsliced state in
//   o_state : 128-bit bitsliced state out, same word layout
module serpent_linear_transform
    import serpent_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    logic [31:0] x0, x1, x2, x3;

    // The transform is a strict sequence of word updates; blocking
    // assignments keep it readable in the same order as the algorithm.
    always_comb begin
        x0 = i_state[31:0];
        x1 = i_state[63:32];
        x2 = i_state[95:64];
        x3 = i_state[127:96];
        x0 = rotl32(x0, 13);
        x2 = rotl32(x2, 3);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = rotl32(x1, 1);
        x3 = rotl32(x3, 7);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = rotl32(x0, 5);
        x2 = rotl32(x2, 22);
        o_state = {x3, x2, x1, x0};
    end

endmodule

// File: rtl/serpent_round_engine.sv
// Iterative Serpent-128 encryption core, one round per clock.
//   i_clk/i_rst_n     : clock, async active-low reset
//   i_valid/o_ready   : input block handshake, i_data is the bitsliced state
//   o_key_idx/i_subkey: subkey request index and the combinationally returned subkey
//   o_valid/i_ready   : result handshake, o_data is the bitsliced ciphertext state
module serpent_round_engine
    import serpent_pkg::*;
#(
    parameter int ROUNDS    = SERPENT_ROUNDS,
    parameter int KEY_IDX_W = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [127:0]         i_data,
    output logic [KEY_IDX_W-1:0] o_key_idx,
    input  logic [127:0]         i_subkey,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [127:0]         o_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [KEY_IDX_W-1:0] LAST_SBOX_RND = KEY_IDX_W'(ROUNDS - 1);
    localparam logic [KEY_IDX_W-1:0] FINAL_MIX_RND = KEY_IDX_W'(ROUNDS);

    fsm_t                 state_q, state_d;
    logic [KEY_IDX_W-1:0] rnd_q, rnd_d;
    state_t               data_q, data_d;

    state_t     key_mixed;
    state_t     sbox_out;
    state_t     lt_out;
    logic [2:0] sbox_idx;

    // The last S-box round always uses S7 and skips the linear transform.
    assign key_mixed = data_q ^ i_subkey;
    assign sbox_idx  = (rnd_q == LAST_SBOX_RND) ? 3'd7 : rnd_q[2:0];
    assign sbox_out  = sbox_slice(sbox_idx, key_mixed);

    serpent_linear_transform u_lt (
        .i_state (sbox_out),
        .o_state (lt_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = RUN;
                    rnd_d   = '0;
                    data_d  = i_data;
                end
            end
            RUN: begin
                if (rnd_q == FINAL_MIX_RND) begin
                    data_d  = key_mixed;
                    rnd_d   = '0;
                    state_d = DONE;
                end else if (rnd_q == LAST_SBOX_RND) begin
                    data_d = sbox_out;
                    rnd_d  = rnd_q + 1'b1;
                end else begin
                    data_d = lt_out;
                    rnd_d  = rnd_q + 1'b1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // o_ready is gated by the reset pin so it stays low while reset is held.
    assign o_ready   = (state_q == IDLE) && i_rst_n;
    assign o_valid   = (state_q == DONE);
    assign o_data    = (state_q == DONE) ? data_q : '0;
    assign o_key_idx = (state_q == RUN) ? rnd_q : '0;

endmodule

// File: tb/tb_serpent_round_engine.sv
// Self-checking bench for serpent_round_engine: table vectors, hand-written
// corner sequences, and randomized blocks against a word-level Serpent model.
module tb_serpent_round_engine;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data;
    logic [5:0]   o_key_idx;
    logic [127:0] i_subkey;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;

    logic [127:0] subkeys [33];

    int total_checks;
    int passed_checks;

    serpent_round_engine #(
        .ROUNDS    (32),
        .KEY_IDX_W (6)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_key_idx (o_key_idx),
        .i_subkey  (i_subkey),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data)
    );

    // Key store model: combinational read of the requested subkey.
    assign i_subkey = (o_key_idx <= 6'd32) ? subkeys[o_key_idx] : 128'd0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    localparam logic [3:0] REF_SBOX [8][16] = '{
        '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
        '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4},
        '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2},
        '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
        '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
        '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1},
        '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0},
        '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6}
    };

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [31:0] w [4];
        logic [31:0] t [4];
        logic [3:0]  nib;
        for (int i = 0; i < 4; i++) w[i] = pt[32*i +: 32];
        for (int r = 0; r < 32; r++) begin
            for (int i = 0; i < 4; i++) w[i] = w[i] ^ subkeys[r][32*i +: 32];
            for (int i = 0; i < 4; i++) t[i] = '0;
            for (int j = 0; j < 32; j++) begin
                nib = REF_SBOX[r % 8][{w[3][j], w[2][j], w[1][j], w[0][j]}];
                for (int i = 0; i < 4; i++) t[i][j] = nib[i];
            end
            for (int i = 0; i < 4; i++) w[i] = t[i];
            if (r < 31) begin
                w[0] = rol(w[0], 13);
                w[2] = rol(w[2], 3);
                w[1] = w[1] ^ w[0] ^ w[2];
                w[3] = w[3] ^ w[2] ^ (w[0] << 3);
                w[1] = rol(w[1], 1);
                w[3] = rol(w[3], 7);
                w[0] = w[0] ^ w[1] ^ w[3];
                w[2] = w[2] ^ w[3] ^ (w[1] << 7);
                w[0] = rol(w[0], 5);
                w[2] = rol(w[2], 22);
            end
        end
        for (int i = 0; i < 4; i++) w[i] = w[i] ^ subkeys[32][32*i +: 32];
        return {w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Deterministic subkey set derived from a seed; seed 0 means all-zero keys.
    task automatic load_keys(input logic [31:0] seed);
        for (int i = 0; i < 33; i++) begin
            if (seed == 32'd0)
                subkeys[i] = '0;
            else
                subkeys[i] = {seed * 32'h9E3779B9 + 32'(i), seed ^ (32'(i) << 8),
                              ~seed + 32'(i), seed * 32'(i + 1)};
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Presents a block and returns at the negedge right after the accepting edge.
    task automatic start_block(input logic [127:0] pt);
        int budget;
        i_valid = 1'b1;
        i_data  = pt;
        budget  = 0;
        while (!o_ready && budget < 100) begin
            @(negedge i_clk);
            budget++;
        end
        if (!o_ready) checkOutput("accept_timeout", 128'd0, 128'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_data  = rand128();
    endtask

    // Counts cycles until o_valid while tracing o_key_idx against 0,1,2,...
    task automatic wait_valid(output int latency, output bit trace_ok);
        int cyc;
        cyc      = 0;
        trace_ok = 1'b1;
        while (!o_valid && cyc < 100) begin
            if (o_key_idx != 6'(cyc)) trace_ok = 1'b0;
            @(negedge i_clk);
            cyc++;
        end
        if (o_key_idx != 6'd0) trace_ok = 1'b0;
        latency = cyc;
    endtask

    task automatic applyStimulus(input logic [127:0] pt, output logic [127:0] result,
                                 output int latency, output bit trace_ok);
        start_block(pt);
        wait_valid(latency, trace_ok);
        result  = o_data;
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    typedef struct {
        logic [127:0] data;
        logic [31:0]  seed;
        logic [127:0] expected;
    } vec_t;

    vec_t         vecs [5];
    logic [127:0] result_q [$];
    logic [127:0] expect_q [$];

    initial begin
        logic [127:0] got;
        logic [127:0] exp_val;
        int           latency;
        bit           trace_ok;
        bit           stable_ok;
        bit           ready_low;
        int           pulses;
        int           budget;
        bit           hs;

        total_checks  = 0;
        passed_checks = 0;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        load_keys(32'd0);

        vecs[0] = '{128'd0, 32'd0, 128'd0};
        vecs[1] = '{{128{1'b1}}, 32'd0, 128'd0};
        vecs[2] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 32'd1, 128'd0};
        vecs[3] = '{128'd0, 32'd7, 128'd0};
        vecs[4] = '{128'h80000000_00000000_00000000_00000001, 32'hDEADBEEF, 128'd0};
        for (int v = 0; v < 5; v++) begin
            load_keys(vecs[v].seed);
            vecs[v].expected = ref_encrypt(vecs[v].data);
        end

        // Reset values while reset is held.
        repeat (3) @(negedge i_clk);
        checkOutput("reset_o_ready", 128'(o_ready), 128'd0);
        checkOutput("reset_o_valid", 128'(o_valid), 128'd0);
        checkOutput("reset_o_key_idx", 128'(o_key_idx), 128'd0);
        checkOutput("reset_o_data", o_data, 128'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("ready_after_reset", 128'(o_ready), 128'd1);

        // Table-driven vectors.
        for (int v = 0; v < 5; v++) begin
            load_keys(vecs[v].seed);
            applyStimulus(vecs[v].data, got, latency, trace_ok);
            checkOutput($sformatf("vec%0d_data", v), got, vecs[v].expected);
            checkOutput($sformatf("vec%0d_latency", v), 128'(latency), 128'd33);
            checkOutput($sformatf("vec%0d_key_trace", v), 128'(trace_ok), 128'd1);
            checkOutput($sformatf("vec%0d_idle_after", v), 128'({o_ready, o_valid}), 128'b10);
        end

        // Backpressure: DONE held for 10 cycles with ignored i_valid pulses.
        load_keys(vecs[2].seed);
        start_block(vecs[2].data);
        wait_valid(latency, trace_ok);
        stable_ok = 1'b1;
        ready_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!(o_valid && o_data === vecs[2].expected)) stable_ok = 1'b0;
            if (o_ready) ready_low = 1'b0;
            i_valid = c[0];
            i_data  = rand128();
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        checkOutput("stall_data_stable", 128'(stable_ok), 128'd1);
        checkOutput("stall_ready_low", 128'(ready_low), 128'd0 + 128'd1);
        checkOutput("stall_final_data", o_data, vecs[2].expected);
        i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("stall_no_capture", 128'({o_ready, o_valid, o_key_idx}), {120'd0, 8'b10_000000});

        // i_ready already high when DONE is entered: one-cycle o_valid pulse.
        load_keys(vecs[3].seed);
        i_ready = 1'b1;
        start_block(vecs[3].data);
        pulses  = 0;
        exp_val = '0;
        for (int c = 0; c < 45; c++) begin
            if (o_valid) begin
                pulses++;
                exp_val = o_data;
            end
            @(negedge i_clk);
        end
        i_ready = 1'b0;
        checkOutput("pulse_width", 128'(pulses), 128'd1);
        checkOutput("pulse_data", exp_val, vecs[3].expected);

        // Reset mid-block at round 17, then a clean block.
        load_keys(vecs[4].seed);
        start_block(vecs[4].data);
        budget = 0;
        while (o_key_idx != 6'd17 && budget < 60) begin
            @(negedge i_clk);
            budget++;
        end
        checkOutput("mid_reset_reach_rnd17", 128'(o_key_idx), 128'd17);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_async", 128'({o_ready, o_valid, o_key_idx}), 128'd0);
        checkOutput("mid_reset_data", o_data, 128'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        applyStimulus(vecs[4].data, got, latency, trace_ok);
        checkOutput("after_reset_data", got, vecs[4].expected);

        // 100 random blocks, i_valid held high, random i_ready.
        i_valid = 1'b1;
        for (int b = 0; b < 100; b++) begin
            budget = 0;
            while (!o_ready && budget < 100) begin
                @(negedge i_clk);
                budget++;
            end
            if (!o_ready) checkOutput("rand_ready_timeout", 128'd0, 128'd1);
            for (int k = 0; k < 33; k++) subkeys[k] = rand128();
            i_data  = rand128();
            exp_val = ref_encrypt(i_data);
            expect_q.push_back(exp_val);
            @(posedge i_clk);
            @(negedge i_clk);
            budget = 0;
            while (!o_valid && budget < 100) begin
                i_data  = rand128();
                i_ready = 1'($urandom_range(0, 1));
                @(negedge i_clk);
                budget++;
            end
            if (!o_valid) checkOutput("rand_valid_timeout", 128'd0, 128'd1);
            hs     = 1'b0;
            budget = 0;
            while (!hs && budget < 50) begin
                i_ready = 1'($urandom_range(0, 1));
                i_data  = rand128();
                got     = o_data;
                @(posedge i_clk);
                hs = i_ready;
                @(negedge i_clk);
                budget++;
            end
            if (hs) result_q.push_back(got);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        checkOutput("rand_block_count", 128'(result_q.size()), 128'd100);
        for (int b = 0; b < 100 && b < result_q.size(); b++) begin
            checkOutput($sformatf("rand_block%0d", b), result_q[b], expect_q[b]);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
